movegen_sdram_arbiter: RTL and testbench
========================================

Name: movegen_sdram_arbiter

Overview:
- Shares the single SDRAM Avalon-MM master port between NUM_REQ piece move-generator accelerators (king, knight, bishop, ...).
- Each accelerator's master port connects to one requester slot.
- The arbiter grants requesters round-robin, one transfer per grant.
- In-order read responses are routed back to the issuing requester through an ID FIFO.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
MAX_OUTSTANDING, 4, maximum read transfers accepted downstream but not yet answered (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_address  in  NUM_REQ*32  requester i address at [32*i+31:32*i]
req_read  in  NUM_REQ  read request, one bit per requester
req_write  in  NUM_REQ  write request, one bit per requester
req_writedata  in  NUM_REQ*32  write data, packed as req_address
req_waitrequest  out  NUM_REQ  per-requester stall
req_readdata  out  32  master_readdata broadcast to all requesters
req_readdatavalid  out  NUM_REQ  one-hot response strobe
master_address  out  32  to SDRAM
master_read  out  1  to SDRAM
master_write  out  1  to SDRAM
master_writedata  out  32  to SDRAM
master_waitrequest  in  1  from SDRAM
master_readdata  in  32  from SDRAM
master_readdatavalid  in  1  from SDRAM
err_orphan  out  1  sticky: response arrived with no outstanding read

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset state:
  - state=IDLE, rr_ptr=0, FIFO empty, count=0, err_orphan=0.
  - master_read=0, master_write=0, master_address=0, master_writedata=0.
  - req_waitrequest all 1s; req_readdatavalid all 0s.
- A requester is active when req_read[i] or req_write[i] is high. If both are high, it is treated as a write; verification flags this as illegal.
- FSM states:
  - IDLE:
    - If any requester is active, pick the first active index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
    - Register it as gnt_id and go to GRANT. Arbitration latency is 1 cycle.
    - Otherwise stay in IDLE.
  - GRANT:
    - master_* outputs are driven combinationally from requester gnt_id.
    - Reads are masked: master_read=0 while count==MAX_OUTSTANDING.
    - req_waitrequest[gnt_id] = master_waitrequest OR (read AND count==MAX_OUTSTANDING).
    - Every other requester sees req_waitrequest=1.
    - Accept condition: command presented downstream and master_waitrequest=0.
    - On accept: rr_ptr <= gnt_id+1 mod NUM_REQ, then go to IDLE. A read accept also pushes gnt_id into the FIFO.
    - If the granted requester drops its command before accept (protocol violation): go to IDLE with rr_ptr unchanged.
- Grant lock: while stalled in GRANT, master_address, master_writedata and the command stay stable and track only gnt_id. No other requester can preempt.
- Throughput: at most one accepted transfer per 2 cycles.
- Response path:
  - When master_readdatavalid=1 and the FIFO is non-empty, pop the head and assert req_readdatavalid[head]=1 for exactly that cycle.
  - req_readdata = master_readdata, combinational.
- Orphan response: master_readdatavalid=1 with the FIFO empty is dropped, no strobe is issued, and err_orphan is set to 1 until reset.
- Counter and FIFO:
  - count tracks FIFO occupancy, range 0..MAX_OUTSTANDING.
  - Push and pop in the same cycle leave count unchanged.
  - A push is never performed at count==MAX_OUTSTANDING, because reads are masked.
  - Pointers are clog2(MAX_OUTSTANDING) bits and wrap naturally.
- Writes never enter the FIFO and produce no response.
- Reset mid-operation: all state clears immediately. In-flight SDRAM responses arriving after reset are treated as orphans.

Test Plan:
- Single read: requester 0 reads 0x40, SDRAM has no waitrequest and returns 0x11223344 two cycles later -> master_read for 1 cycle at 0x40; req_readdatavalid=4'b0001 with req_readdata=0x11223344; err_orphan=0.
- Round-robin: requesters 0 and 2 both hold write requests continuously for 4 transfers -> downstream order is 0,2,0,2; each transfer carries its own writedata; requesters 1 and 3 see waitrequest=1 throughout.
- Stall lock: grant requester 1 writing 0x200; master_waitrequest=1 for 5 cycles while requester 3 also requests -> master_address stays 0x200 for all 6 cycles; req_waitrequest[3]=1; requester 3 is granted next.
- Response routing: reads issued in order by requesters 3, 0, 1; SDRAM answers in order after a delay -> strobes are 4'b1000, 4'b0001, 4'b0010 in that order.
- FIFO full: 4 reads accepted with no responses -> 5th read shows master_read=0 and req_waitrequest=1; after one response it is accepted on the next GRANT cycle.
- Orphan and reset: assert master_readdatavalid with the FIFO empty -> err_orphan=1 and no strobe. Assert rst_n=0 with 2 reads outstanding -> FIFO cleared and err_orphan=0; later responses set err_orphan=1.

Source files
------------

// File: rtl/movegen_sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon-MM master between NUM_REQ move-generator
// accelerators; in-order read responses are steered back through a small ID FIFO.
module movegen_sdram_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ*32-1:0]   req_address,
  input  logic [NUM_REQ-1:0]      req_read,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [NUM_REQ*32-1:0]   req_writedata,
  output logic [NUM_REQ-1:0]      req_waitrequest,
  output logic [31:0]             req_readdata,
  output logic [NUM_REQ-1:0]      req_readdatavalid,
  output logic [31:0]             master_address,
  output logic                    master_read,
  output logic                    master_write,
  output logic [31:0]             master_writedata,
  input  logic                    master_waitrequest,
  input  logic [31:0]             master_readdata,
  input  logic                    master_readdatavalid,
  output logic                    err_orphan
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, gnt_id_q, gnt_id_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [IW-1:0] fifo_q [MAX_OUTSTANDING];

  logic [NUM_REQ-1:0] act;
  logic               full, g_wr, g_rd, push, pop, found;
  logic [IW-1:0]      pick;

  assign act          = req_read | req_write;
  assign full         = (count_q == CW'(MAX_OUTSTANDING));
  // read+write together is treated as a write
  assign g_wr         = req_write[gnt_id_q];
  assign g_rd         = req_read[gnt_id_q] & ~g_wr;
  assign pop          = master_readdatavalid & (count_q != '0);
  assign req_readdata = master_readdata;
  assign err_orphan   = err_q;

  // first active requester at or after rr_ptr
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && act[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        pick  = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    master_address   = '0;
    master_writedata = '0;
    master_read      = 1'b0;
    master_write     = 1'b0;
    req_waitrequest  = '1;
    if (state_q == GRANT) begin
      master_address            = req_address[int'(gnt_id_q)*32 +: 32];
      master_writedata          = req_writedata[int'(gnt_id_q)*32 +: 32];
      master_write              = g_wr;
      master_read               = g_rd & ~full;
      req_waitrequest[gnt_id_q] = master_waitrequest | (g_rd & full);
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_id_d = gnt_id_q;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_id_d = pick;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if ((master_read | master_write) & ~master_waitrequest) begin
          rr_ptr_d = (gnt_id_q == IW'(NUM_REQ - 1)) ? '0 : gnt_id_q + IW'(1);
          push     = master_read;
          state_d  = IDLE;
        end else if (!(g_rd | g_wr)) begin
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    err_d    = err_q | (master_readdatavalid & (count_q == '0));
  end

  always_comb begin
    req_readdatavalid = '0;
    if (pop) req_readdatavalid[fifo_q[rd_ptr_q]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_id_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_id_q <= gnt_id_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      if (push) fifo_q[wr_ptr_q] <= gnt_id_q;
    end
  end
endmodule

// File: tb/tb_movegen_sdram_arbiter.sv
// Random Avalon requesters and SDRAM against a transaction-level model: round-robin
// pick, in-order ID queue for responses, sticky orphan flag, mid-run resets.
module tb_movegen_sdram_arbiter;
  localparam int N      = 4;
  localparam int MAXO   = 4;
  localparam int CYCLES = 3000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*32-1:0] req_address, req_writedata;
  logic [N-1:0]   req_read, req_write, req_waitrequest, req_readdatavalid;
  logic [31:0]    req_readdata, master_address, master_writedata, master_readdata;
  logic           master_read, master_write, master_waitrequest, master_readdatavalid;
  logic           err_orphan;

  always #5 clk = ~clk;

  movegen_sdram_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_address(req_address), .req_read(req_read), .req_write(req_write),
    .req_writedata(req_writedata), .req_waitrequest(req_waitrequest),
    .req_readdata(req_readdata), .req_readdatavalid(req_readdatavalid),
    .master_address(master_address), .master_read(master_read),
    .master_write(master_write), .master_writedata(master_writedata),
    .master_waitrequest(master_waitrequest), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid), .err_orphan(err_orphan)
  );

  typedef struct { int due; logic [31:0] data; } rsp_t;

  bit          rd [N];
  bit          wr [N];
  logic [31:0] ra [N];
  logic [31:0] rwd[N];
  bit          m_busy, m_err;
  int          m_gnt, m_rr;
  int          m_q[$];
  rsp_t        sq[$];
  int          cyc, n_cmp, n_bad;
  int          stall_pct, dmin, dmax, orph_pct, req_pct;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive();
    rst_n = !((cyc < 3) || (cyc >= 1200 && cyc < 1202) || (cyc >= 2000 && cyc < 2003));
    if (cyc < 800)       begin stall_pct = 20; dmin = 1;  dmax = 4;  orph_pct = 0; req_pct = 40; end
    else if (cyc < 1600) begin stall_pct = 10; dmin = 15; dmax = 40; orph_pct = 0; req_pct = 60; end
    else if (cyc < 2400) begin stall_pct = 50; dmin = 1;  dmax = 8;  orph_pct = 5; req_pct = 30; end
    else                 begin stall_pct = 0;  dmin = 2;  dmax = 3;  orph_pct = 2; req_pct = 80; end
    for (int i = 0; i < N; i++) begin
      if (!rd[i] && !wr[i] && int'($urandom_range(99)) < req_pct) begin
        if ($urandom_range(1) == 1) wr[i] = 1'b1; else rd[i] = 1'b1;
        ra[i]  = {4'(i), 28'($urandom)};
        rwd[i] = $urandom;
      end
      req_read[i]               = rd[i];
      req_write[i]              = wr[i];
      req_address[32*i +: 32]   = ra[i];
      req_writedata[32*i +: 32] = rwd[i];
    end
    master_waitrequest   = int'($urandom_range(99)) < stall_pct;
    master_readdata      = $urandom;
    master_readdatavalid = 1'b0;
    if (sq.size() > 0 && sq[0].due <= cyc) begin
      master_readdatavalid = 1'b1;
      master_readdata      = sq[0].data;
      void'(sq.pop_front());
    end else if (sq.size() == 0 && int'($urandom_range(99)) < orph_pct) begin
      master_readdatavalid = 1'b1;
    end
  endtask

  task automatic check_and_update();
    logic [N-1:0] act, exp_wait, exp_rdv;
    bit           isr, isw, full, emr, emw;
    logic [31:0]  ea, ewd;
    int           g;
    if (!rst_n) begin
      m_busy = 0; m_rr = 0; m_err = 0; m_q.delete();
      chk("rst_mread",  master_read, 0);
      chk("rst_mwrite", master_write, 0);
      chk("rst_maddr",  master_address, 0);
      chk("rst_mwdata", master_writedata, 0);
      chk("rst_wait",   req_waitrequest, {N{1'b1}});
      chk("rst_rdv",    req_readdatavalid, 0);
      chk("rst_err",    err_orphan, 0);
      return;
    end
    emr = 0; emw = 0; ea = '0; ewd = '0; exp_wait = '1; g = 0;
    full = (m_q.size() == MAXO);
    for (int i = 0; i < N; i++) act[i] = rd[i] | wr[i];
    if (m_busy) begin
      g   = m_gnt;
      isw = wr[g];
      isr = rd[g] && !wr[g];
      emr = isr && !full;
      emw = isw;
      ea  = ra[g];
      ewd = rwd[g];
      exp_wait[g] = master_waitrequest | (isr && full);
    end
    chk("mread",  master_read, emr);
    chk("mwrite", master_write, emw);
    chk("maddr",  master_address, ea);
    chk("mwdata", master_writedata, ewd);
    chk("wait",   req_waitrequest, exp_wait);
    chk("err",    err_orphan, m_err);
    exp_rdv = '0;
    if (master_readdatavalid) begin
      if (m_q.size() > 0) begin
        exp_rdv[m_q[0]] = 1'b1;
        void'(m_q.pop_front());
      end else m_err = 1;
    end
    chk("rdv",   req_readdatavalid, exp_rdv);
    chk("rdata", req_readdata, master_readdata);
    // SDRAM side queues an answer for every accepted read; requesters drop on accept
    if (master_read && !master_waitrequest)
      sq.push_back('{due: cyc + int'($urandom_range(dmax, dmin)), data: $urandom});
    for (int i = 0; i < N; i++)
      if (act[i] && !req_waitrequest[i]) begin rd[i] = 0; wr[i] = 0; end
    if (m_busy) begin
      if ((emr || emw) && !master_waitrequest) begin
        m_rr = (g + 1) % N;
        if (emr) m_q.push_back(g);
        m_busy = 0;
      end
    end else begin
      for (int k = 0; k < N; k++)
        if (!m_busy && act[(m_rr + k) % N]) begin
          m_gnt  = (m_rr + k) % N;
          m_busy = 1;
        end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    m_busy = 0; m_err = 0; m_gnt = 0; m_rr = 0;
    rst_n = 1'b0;
    req_address = '0; req_writedata = '0; req_read = '0; req_write = '0;
    master_waitrequest = 1'b0; master_readdata = '0; master_readdatavalid = 1'b0;
    for (int i = 0; i < N; i++) begin rd[i] = 0; wr[i] = 0; ra[i] = '0; rwd[i] = '0; end
    for (cyc = 0; cyc < CYCLES; cyc++) begin
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      check_and_update();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
